// File: rtl/fifo_reader_pkg.sv
// Shared types and default widths for the fifo_reader burst-read controller.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 7;
  localparam int DEF_BCNT_W = 16;
  localparam int BUF_DEPTH  = 2;
  localparam int OCC_W      = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_reader_if.sv
// FIFO read-side and output-stream signals of fifo_reader; master is the reader itself.
interface fifo_reader_if #(
  parameter int DATA_W = fifo_reader_pkg::DEF_DATA_W,
  parameter int CNT_W  = fifo_reader_pkg::DEF_CNT_W
) ();

  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (
    input  fifo_empty, fifo_count, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data, m_last
  );

  modport slave (
    output fifo_empty, fifo_count, fifo_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, m_last
  );

endinterface

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order output buffer of {last, data}; head entry drives the stream directly.
// Zero-latency push-to-head when empty; caller must never push into a full buffer without popping.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_last_o,
  output logic [OCC_W-1:0]  occ_o
);

  logic [DATA_W:0]  head_q, head_d;
  logic [DATA_W:0]  tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             valid_q, valid_d;
  logic             pop;
  logic [DATA_W:0]  word;

  assign pop  = valid_q && m_ready_i;
  assign word = {push_last_i, push_data_i};

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push_i, pop})
      2'b10: begin
        if (occ_q == '0) head_d = word;
        else             tail_d = word;
        occ_d = occ_q + 1'b1;
      end
      2'b01: begin
        if (occ_q == OCC_W'(BUF_DEPTH)) head_d = tail_q;
        occ_d = occ_q - 1'b1;
      end
      2'b11: begin
        // Simultaneous push/pop keeps occupancy; the new word lands behind any older one.
        if (occ_q == OCC_W'(1)) begin
          head_d = word;
        end else begin
          head_d = tail_q;
          tail_d = word;
        end
      end
      default: ;
    endcase
    valid_d = (occ_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= valid_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = head_q[DATA_W-1:0];
  assign m_last_o  = head_q[DATA_W];
  assign occ_o     = occ_q;

endmodule

// File: rtl/fifo_reader.sv
// Burst reader: waits for BURST_LEN words, drains them, re-streams with last marker; rd_en->m_valid 2 cycles.
// Reads are throttled so buffered plus in-flight words never exceed the 2-entry output buffer.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int BURST_LEN = 8,
  parameter int BCNT_W    = DEF_BCNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  fifo_reader_if.master     bus,
  output logic              busy,
  output logic [BCNT_W-1:0] burst_cnt
);

  localparam logic [CNT_W-1:0] BLEN    = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] BLEN_M1 = CNT_W'(BURST_LEN - 1);
  localparam logic [OCC_W:0]   DEPTH_V = (OCC_W + 1)'(BUF_DEPTH);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic              inflight_q;
  logic              busy_q;

  logic              rd_en;
  logic              pop;
  logic              push_last;
  logic              sk_valid;
  logic              sk_last;
  logic [DATA_W-1:0] sk_data;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W:0]    occ_next;

  // Buffer occupancy one cycle ahead, counting the word already requested from the FIFO.
  assign pop       = sk_valid && bus.m_ready;
  assign occ_next  = {1'b0, occ} + {{OCC_W{1'b0}}, inflight_q} - {{OCC_W{1'b0}}, pop};
  assign push_last = inflight_q && (rd_cnt_q == BLEN);

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    burst_cnt_d = burst_cnt_q;
    rd_en       = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (bus.fifo_count >= BLEN)) begin
          state_d  = BURST;
          rd_cnt_d = '0;
        end
      end
      BURST: begin
        rd_en = !bus.fifo_empty && (rd_cnt_q != BLEN) && (occ_next < DEPTH_V);
        if (rd_en) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == BLEN_M1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((occ_next == '0) && !inflight_q) begin
          state_d     = IDLE;
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      burst_cnt_q <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      burst_cnt_q <= burst_cnt_d;
      inflight_q  <= rd_en;
      busy_q      <= (state_d != IDLE);
    end
  end

  fifo_reader_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (bus.fifo_data),
    .push_last_i (push_last),
    .m_valid_o   (sk_valid),
    .m_ready_i   (bus.m_ready),
    .m_data_o    (sk_data),
    .m_last_o    (sk_last),
    .occ_o       (occ)
  );

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = sk_valid;
  assign bus.m_data     = sk_data;
  assign bus.m_last     = sk_last;
  assign busy           = busy_q;
  assign burst_cnt      = burst_cnt_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: behavioural FIFO, expected-stream scoreboard, cycle-exact timing checks.
module tb_fifo_reader;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 7;
  localparam int BLEN   = 8;
  localparam int BCNT_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              busy;
  logic [BCNT_W-1:0] burst_cnt;

  fifo_reader_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  fifo_reader #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .BURST_LEN(BLEN), .BCNT_W(BCNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus),
    .busy(busy), .burst_cnt(burst_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W:0]   got_q[$];

  int reads = 0, delivered = 0, prev_rd = 0, max_occ = 0;
  int stab_viol = 0, rd_on_empty = 0, rd_pulses = 0;
  int force_empty = 0, stall_after = 0, exp_bursts = 0;

  logic              s_rd, s_valid, s_ready, s_last, s_busy;
  logic [DATA_W-1:0] s_data;
  logic [BCNT_W-1:0] s_bcnt;
  logic              p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
  logic [DATA_W-1:0] p_data = '0;

  task automatic update_io();
    bus.fifo_empty = (q.size() == 0) || (force_empty > 0);
    bus.fifo_count = (q.size() > 127) ? 7'd127 : CNT_W'(q.size());
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    q.push_back(d);
    exp_q.push_back(d);
    update_io();
  endtask

  // Sample at the falling edge, then advance to just after the next rising edge and model the FIFO.
  task automatic cycle();
    int occ_est;
    @(negedge clk);
    s_rd = bus.fifo_rd_en; s_valid = bus.m_valid; s_ready = bus.m_ready;
    s_data = bus.m_data; s_last = bus.m_last; s_busy = busy; s_bcnt = burst_cnt;
    if (s_rd && bus.fifo_empty) rd_on_empty++;
    occ_est = reads - delivered - prev_rd;
    if (occ_est > max_occ) max_occ = occ_est;
    if (p_valid && !p_ready && (!s_valid || s_data !== p_data || s_last !== p_last)) stab_viol++;
    if (s_valid && s_ready) begin
      got_q.push_back({s_last, s_data});
      delivered++;
    end
    p_valid = s_valid; p_ready = s_ready; p_data = s_data; p_last = s_last;
    prev_rd = (s_rd && !bus.fifo_empty) ? 1 : 0;
    @(posedge clk);
    #1;
    if (s_rd && rst_n && q.size() > 0) begin
      bus.fifo_data = q.pop_front();
      reads++;
      rd_pulses++;
    end
    if (force_empty > 0) force_empty--;
    if (stall_after != 0 && reads == stall_after) begin
      force_empty = 4;
      stall_after = 0;
    end
    update_io();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; bus.m_ready = 1'b0; bus.fifo_data = 8'hA5;
    update_io();
    repeat (3) cycle();
    n_checks++; if (s_rd !== 1'b0)    begin n_fail++; $display("FAIL rst_rd_en: got %b want 0", s_rd); end
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b want 0", s_valid); end
    n_checks++; if (s_data !== '0)    begin n_fail++; $display("FAIL rst_m_data: got %h want 00", s_data); end
    n_checks++; if (s_last !== 1'b0)  begin n_fail++; $display("FAIL rst_m_last: got %b want 0", s_last); end
    n_checks++; if (s_busy !== 1'b0)  begin n_fail++; $display("FAIL rst_busy: got %b want 0", s_busy); end
    n_checks++; if (s_bcnt !== '0)    begin n_fail++; $display("FAIL rst_burst_cnt: got %0d want 0", s_bcnt); end
  endtask

  task automatic test_threshold();
    rst_n = 1'b1; enable = 1'b1; bus.m_ready = 1'b1;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < BLEN - 1; i++) push_word(8'($urandom));
    for (int c = 0; c < 5; c++) begin
      cycle();
      n_checks++;
      if (s_rd !== 1'b0 || s_valid !== 1'b0 || s_busy !== 1'b0 || s_bcnt !== '0 || s_data !== '0 || s_last !== 1'b0) begin
        n_fail++;
        $display("FAIL thr_idle c%0d: rd=%b valid=%b busy=%b bcnt=%0d data=%h last=%b want all zero",
                 c, s_rd, s_valid, s_busy, s_bcnt, s_data, s_last);
      end
    end
    push_word(8'($urandom));
    cycle();
    n_checks++; if (s_rd !== 1'b0) begin n_fail++; $display("FAIL thr_cycle0_rd: got %b want 0", s_rd); end
    cycle();
    n_checks++; if (s_rd !== 1'b1) begin n_fail++; $display("FAIL thr_cycle1_rd: got %b want 1", s_rd); end
    for (int i = 0; i < 60 && (got_q.size() < BLEN || s_busy); i++) cycle();
    exp_bursts++;
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL thr_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== {1'(i % BLEN == BLEN - 1), exp_q[i]}) begin
        n_fail++; $display("FAIL thr_word%0d: got %h want %h", i, got_q[i], {1'(i % BLEN == BLEN - 1), exp_q[i]});
      end
    end
    n_checks++; if (s_bcnt !== BCNT_W'(exp_bursts)) begin n_fail++; $display("FAIL thr_bcnt: got %0d want %0d", s_bcnt, exp_bursts); end
  endtask

  task automatic test_full_rate_back_to_back();
    logic e_rd, e_valid, e_busy;
    logic [BCNT_W-1:0] base;
    base = BCNT_W'(exp_bursts);
    exp_q.delete(); got_q.delete();
    enable = 1'b1; bus.m_ready = 1'b1;
    for (int i = 0; i < BLEN; i++) push_word(8'(8'h10 + i));
    for (int i = 0; i < BLEN; i++) push_word(8'($urandom));
    for (int c = 0; c <= 12; c++) begin
      cycle();
      e_rd    = (c >= 1 && c <= 8) || (c == 12);
      e_valid = (c >= 3 && c <= 10);
      e_busy  = (c >= 1 && c <= 10) || (c == 12);
      n_checks++; if (s_rd !== e_rd)       begin n_fail++; $display("FAIL fr_rd c%0d: got %b want %b", c, s_rd, e_rd); end
      n_checks++; if (s_valid !== e_valid) begin n_fail++; $display("FAIL fr_valid c%0d: got %b want %b", c, s_valid, e_valid); end
      n_checks++; if (s_busy !== e_busy)   begin n_fail++; $display("FAIL fr_busy c%0d: got %b want %b", c, s_busy, e_busy); end
      n_checks++;
      if (s_bcnt !== base + BCNT_W'(c >= 11)) begin n_fail++; $display("FAIL fr_bcnt c%0d: got %0d want %0d", c, s_bcnt, base + BCNT_W'(c >= 11)); end
      if (e_valid) begin
        n_checks++;
        if (s_data !== 8'(8'h10 + c - 3) || s_last !== (c == 10)) begin
          n_fail++; $display("FAIL fr_data c%0d: got %h/%b want %h/%b", c, s_data, s_last, 8'(8'h10 + c - 3), (c == 10));
        end
      end
    end
    for (int i = 0; i < 60 && (got_q.size() < 2 * BLEN || s_busy); i++) cycle();
    exp_bursts += 2;
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL fr_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== {1'(i % BLEN == BLEN - 1), exp_q[i]}) begin
        n_fail++; $display("FAIL fr_word%0d: got %h want %h", i, got_q[i], {1'(i % BLEN == BLEN - 1), exp_q[i]});
      end
    end
    n_checks++; if (s_bcnt !== BCNT_W'(exp_bursts)) begin n_fail++; $display("FAIL fr_bcnt_end: got %0d want %0d", s_bcnt, exp_bursts); end
  endtask

  task automatic test_backpressure();
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    exp_q.delete(); got_q.delete();
    max_occ = 0; stab_viol = 0; enable = 1'b1;
    for (int i = 0; i < 2 * BLEN; i++) push_word(8'($urandom));
    for (int k = 0; k < 300 && got_q.size() < 2 * BLEN; k++) begin
      bus.m_ready = pat[k % 4];
      cycle();
    end
    bus.m_ready = 1'b1;
    for (int i = 0; i < 20 && s_busy; i++) cycle();
    exp_bursts += 2;
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d words want %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== {1'(i % BLEN == BLEN - 1), exp_q[i]}) begin
        n_fail++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], {1'(i % BLEN == BLEN - 1), exp_q[i]});
      end
    end
    n_checks++; if (max_occ !== 2)   begin n_fail++; $display("FAIL bp_max_occ: got %0d want 2", max_occ); end
    n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stab_viol); end
    n_checks++; if (s_bcnt !== BCNT_W'(exp_bursts)) begin n_fail++; $display("FAIL bp_bcnt: got %0d want %0d", s_bcnt, exp_bursts); end
  endtask

  task automatic test_mid_disable();
    exp_q.delete(); got_q.delete();
    enable = 1'b1; bus.m_ready = 1'b1; rd_pulses = 0;
    for (int i = 0; i < 20; i++) push_word(8'($urandom));
    for (int c = 0; c < 30; c++) begin
      if (c == 3) enable = 1'b0;
      cycle();
    end
    exp_bursts++;
    n_checks++;
    if (got_q.size() !== BLEN) begin n_fail++; $display("FAIL dis_count: got %0d words want %0d", got_q.size(), BLEN); end
    for (int i = 0; i < got_q.size() && i < BLEN; i++) begin
      n_checks++;
      if (got_q[i] !== {1'(i == BLEN - 1), exp_q[i]}) begin
        n_fail++; $display("FAIL dis_word%0d: got %h want %h", i, got_q[i], {1'(i == BLEN - 1), exp_q[i]});
      end
    end
    n_checks++; if (rd_pulses !== BLEN) begin n_fail++; $display("FAIL dis_reads: got %0d want %0d", rd_pulses, BLEN); end
    n_checks++; if (q.size() !== 12)    begin n_fail++; $display("FAIL dis_left: got %0d words left want 12", q.size()); end
    n_checks++; if (s_busy !== 1'b0)    begin n_fail++; $display("FAIL dis_busy: got %b want 0", s_busy); end
    n_checks++; if (s_bcnt !== BCNT_W'(exp_bursts)) begin n_fail++; $display("FAIL dis_bcnt: got %0d want %0d", s_bcnt, exp_bursts); end
    q.delete();
    update_io();
    enable = 1'b1;
  endtask

  task automatic test_empty_stall();
    int last_c;
    exp_q.delete(); got_q.delete();
    rd_pulses = 0; rd_on_empty = 0; last_c = -1;
    enable = 1'b1; bus.m_ready = 1'b1;
    stall_after = reads + 5;
    for (int i = 0; i < BLEN; i++) push_word(8'($urandom));
    for (int c = 0; c < 60 && (got_q.size() < BLEN || s_busy); c++) begin
      cycle();
      if (s_valid && s_ready && s_last) last_c = c;
    end
    exp_bursts++;
    n_checks++;
    if (got_q.size() !== BLEN) begin n_fail++; $display("FAIL stall_count: got %0d words want %0d", got_q.size(), BLEN); end
    for (int i = 0; i < got_q.size() && i < BLEN; i++) begin
      n_checks++;
      if (got_q[i] !== {1'(i == BLEN - 1), exp_q[i]}) begin
        n_fail++; $display("FAIL stall_word%0d: got %h want %h", i, got_q[i], {1'(i == BLEN - 1), exp_q[i]});
      end
    end
    n_checks++; if (rd_on_empty !== 0) begin n_fail++; $display("FAIL stall_rd_on_empty: got %0d want 0", rd_on_empty); end
    n_checks++; if (rd_pulses !== BLEN) begin n_fail++; $display("FAIL stall_reads: got %0d want %0d", rd_pulses, BLEN); end
    n_checks++; if (last_c !== 14)     begin n_fail++; $display("FAIL stall_last_cycle: got %0d want 14", last_c); end
    n_checks++; if (s_bcnt !== BCNT_W'(exp_bursts)) begin n_fail++; $display("FAIL stall_bcnt: got %0d want %0d", s_bcnt, exp_bursts); end
  endtask

  task automatic test_reset_mid_burst();
    exp_q.delete(); got_q.delete();
    enable = 1'b1; bus.m_ready = 1'b1;
    for (int i = 0; i < BLEN; i++) push_word(8'($urandom));
    for (int i = 0; i < 40 && got_q.size() < 3; i++) cycle();
    n_checks++; if (got_q.size() !== 3) begin n_fail++; $display("FAIL rm_pre: got %0d words want 3", got_q.size()); end
    rst_n = 1'b0;
    cycle();
    n_checks++;
    if (s_rd !== 1'b0 || s_valid !== 1'b0 || s_data !== '0 || s_last !== 1'b0 || s_busy !== 1'b0 || s_bcnt !== '0) begin
      n_fail++;
      $display("FAIL rm_reset: rd=%b valid=%b data=%h last=%b busy=%b bcnt=%0d want all zero",
               s_rd, s_valid, s_data, s_last, s_busy, s_bcnt);
    end
    rst_n = 1'b1;
    q.delete(); exp_q.delete(); got_q.delete();
    reads = 0; delivered = 0; prev_rd = 0; p_valid = 1'b0; exp_bursts = 0;
    for (int i = 0; i < BLEN; i++) push_word(8'($urandom));
    for (int i = 0; i < 60 && (got_q.size() < BLEN || s_busy); i++) cycle();
    exp_bursts++;
    n_checks++;
    if (got_q.size() !== BLEN) begin n_fail++; $display("FAIL rm_count: got %0d words want %0d", got_q.size(), BLEN); end
    for (int i = 0; i < got_q.size() && i < BLEN; i++) begin
      n_checks++;
      if (got_q[i] !== {1'(i == BLEN - 1), exp_q[i]}) begin
        n_fail++; $display("FAIL rm_word%0d: got %h want %h", i, got_q[i], {1'(i == BLEN - 1), exp_q[i]});
      end
    end
    n_checks++; if (s_bcnt !== BCNT_W'(exp_bursts)) begin n_fail++; $display("FAIL rm_bcnt: got %0d want %0d", s_bcnt, exp_bursts); end
  endtask

  task automatic test_random();
    int total, pushed, exp_n;
    for (int r = 0; r < 3; r++) begin
      exp_q.delete(); got_q.delete();
      max_occ = 0; stab_viol = 0;
      total = $urandom_range(12, 30);
      exp_n = (total / BLEN) * BLEN;
      pushed = 0;
      for (int k = 0; k < 1500 && !(pushed == total && got_q.size() >= exp_n && !s_busy); k++) begin
        if (pushed < total && $urandom_range(0, 1) == 1) begin
          push_word(8'($urandom));
          pushed++;
        end
        bus.m_ready = ($urandom_range(0, 3) != 0);
        enable      = ($urandom_range(0, 3) != 0);
        cycle();
      end
      exp_bursts += exp_n / BLEN;
      n_checks++;
      if (got_q.size() !== exp_n) begin n_fail++; $display("FAIL rnd%0d_count: got %0d words want %0d", r, got_q.size(), exp_n); end
      for (int i = 0; i < got_q.size() && i < exp_n; i++) begin
        n_checks++;
        if (got_q[i] !== {1'(i % BLEN == BLEN - 1), exp_q[i]}) begin
          n_fail++; $display("FAIL rnd%0d_word%0d: got %h want %h", r, i, got_q[i], {1'(i % BLEN == BLEN - 1), exp_q[i]});
        end
      end
      n_checks++; if (max_occ > 2)     begin n_fail++; $display("FAIL rnd%0d_occ: got %0d want <=2", r, max_occ); end
      n_checks++; if (stab_viol !== 0) begin n_fail++; $display("FAIL rnd%0d_stable: got %0d want 0", r, stab_viol); end
      n_checks++; if (s_bcnt !== BCNT_W'(exp_bursts)) begin n_fail++; $display("FAIL rnd%0d_bcnt: got %0d want %0d", r, s_bcnt, exp_bursts); end
      q.delete();
      update_io();
    end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_full_rate_back_to_back();
    test_backpressure();
    test_mid_disable();
    test_empty_stall();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Burst-read controller that sits on the read side of the team's single-clock FIFO, the consumer end of its `rd_en`/`buf_empty`/`buf_out` interface. It waits until the FIFO holds a full burst, drains exactly `BURST_LEN` words, and re-presents them on a registered valid/ready stream with an end-of-burst marker. It absorbs the FIFO's one-cycle read latency and never drops or duplicates a word under downstream backpressure.

## Interface
- `DATA_W`, default 8, FIFO word width.
- `CNT_W`, default 7, width of the FIFO occupancy count.
- `BURST_LEN`, default 8, words per burst; legal range 1..2^CNT_W−1.
- `BCNT_W`, default 16, width of the completed-burst counter.

- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: permits starting a new burst.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_count` in CNT_W: FIFO occupancy.
- `fifo_data` in DATA_W: FIFO registered read data, valid the cycle after an accepted read.
- `fifo_rd_en` out 1: FIFO read strobe.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accepts the word.
- `m_data` out DATA_W: output word.
- `m_last` out 1: marks the final word of a burst.
- `busy` out 1: high in BURST or DRAIN.
- `burst_cnt` out BCNT_W: number of completed bursts, wraps modulo 2^BCNT_W.

## Operation
- States: IDLE, BURST, DRAIN.
- IDLE to BURST when `enable` is high and `fifo_count >= BURST_LEN`. The issued-read counter clears.
- In BURST, `fifo_rd_en = !fifo_empty && (occ − pop + inflight) < 2`. The read also stops once `BURST_LEN` reads have been issued.
  - `occ` is the output buffer occupancy (0..2).
  - `pop = m_valid && m_ready`.
  - `inflight` is the registered `fifo_rd_en` from the previous cycle.
- BURST to DRAIN in the cycle after the `BURST_LEN`-th read is issued.
- DRAIN to IDLE once `occ == 0`, `inflight == 0` and no word is being captured. `burst_cnt` increments on that transition.
- A deasserted `enable` mid-burst has no effect; the burst always completes. `enable` is sampled only in IDLE.
- Each word returned by the FIFO is captured into the 2-entry output buffer. The word produced by the `BURST_LEN`-th read carries `last = 1`.
- The output follows valid/ready rules:
  - Once `m_valid` is high, `m_valid`, `m_data` and `m_last` hold until `m_ready` is high.
  - A word transfers when `m_valid && m_ready` are high at a clock edge.
- The `fifo_empty` gating is defensive. If the FIFO empties mid-burst, reads stall and resume when data returns; the burst length is unchanged.
- Reset mid-operation clears state, counters and the buffer. Any in-flight FIFO word is discarded.

## Timing
- Reset values: `fifo_rd_en` 0, `m_valid` 0, `m_data` 0, `m_last` 0, `busy` 0, `burst_cnt` 0. State is IDLE.
- All outputs are registered except `fifo_rd_en`. It is combinational from state, counters, `occ`, `inflight`, `m_valid`, `m_ready` and `fifo_empty`, and has no path from `fifo_data`.
- Start condition true in cycle 0:
  - State is BURST and the first `fifo_rd_en` is in cycle 1.
  - `fifo_data` is valid in cycle 2.
  - `m_valid` first goes high in cycle 3.
- Latency from `fifo_rd_en` to `m_valid` is 2 cycles.
- With `m_ready` held high, throughput is 1 word/cycle. For `BURST_LEN` = 8:
  - `fifo_rd_en` is high in cycles 1–8.
  - `m_valid` is high in cycles 3–10, with `m_last` in cycle 10.
  - `busy` is low and `burst_cnt` increments in cycle 11.
  - A back-to-back burst can start with its first read in cycle 12.
- Backpressure: at most 2 words are buffered. `fifo_rd_en` is low whenever a third word would not fit.

## Structure
- Package `fifo_reader_pkg`:
  - State enum typedef (IDLE, BURST, DRAIN).
  - Default width constants (`DATA_W`, `CNT_W`, `BCNT_W`).
  - Buffer depth constant 2.
- Sub-module `fifo_reader_skid`: 2-entry FIFO-ordered output buffer holding {last, data}.
  - Ports: push, push data, push last, `m_*` side, and `occ` out.
- Top level holds the FSM, the issued-read counter, the `inflight` register and `burst_cnt`.

## Test plan
- Reset and threshold: after reset, `fifo_count` = 7 with `enable` = 1 → `fifo_rd_en` stays 0 and all outputs stay at reset values. Raising `fifo_count` to 8 → first `fifo_rd_en` 1 cycle later.
- Full-rate burst: FIFO preloaded with 0x10..0x17, `m_ready` = 1 → `m_data` is 0x10..0x17 in cycles 3–10, `m_last` only on 0x17, `burst_cnt` = 1 in cycle 11.
- Backpressure: `m_ready` toggles 1,0,0,1 repeatedly → every word is delivered exactly once and in order, `occ` never exceeds 2, and `m_data` is stable while `m_valid && !m_ready`.
- Mid-burst disable: `enable` dropped in cycle 3 of a burst → all 8 words are delivered and no new burst starts, though `fifo_count` = 20.
- Empty stall: FIFO empties after 5 words and refills 4 cycles later → reads pause and the burst completes with exactly 8 words, `m_last` on the 8th.
- Reset mid-burst: `rst_n` low for 1 cycle after 3 words → all outputs at reset values, `burst_cnt` = 0. A fresh burst then starts from IDLE.
